// File: rtl/uart_rx_fifo_feeder.sv
// 8N1 serial receiver that writes each good byte straight into a 16-deep byte FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits (8E1).
module uart_rx_fifo_feeder #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       fifo_full,
    input  logic       clr_err,
    output logic       fifo_wr,
    output logic [7:0] fifo_din,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          rx_meta;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          at_half;
    logic          at_last;
    logic          cnt_clr;
    logic          shift_en;
    logic          wr_set;
    logic          ovr_set;
    logic          fe_set;

    // Synchronizer resets to the idle line level so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign at_half = (cnt == CNT_HALF);
    assign at_last = (cnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
    logic parity_bad;
    logic pe_set;
    assign parity_bad = ^{shift, rxs};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    next_state = START;
                end
            end
            START: begin
                if (at_half) begin
                    next_state = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (at_last && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (at_last) begin
                    next_state = parity_bad ? IDLE : STOP;
                end
`else
                next_state = IDLE;
`endif
            end
            STOP: begin
                if (at_last) begin
                    next_state = rxs ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The bit timer restarts on every state change so each state measures from its own entry
    always_comb begin
        cnt_clr  = (next_state != state) || at_last || (state == IDLE);
        shift_en = (state == DATA) && at_last;
        wr_set   = (state == STOP) && at_last && rxs && !fifo_full;
        ovr_set  = (state == STOP) && at_last && rxs && fifo_full;
        fe_set   = (state == STOP) && at_last && !rxs;
`ifdef UART_RX_PARITY_EN
        pe_set   = (state == PARITY) && at_last && parity_bad;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            fifo_wr   <= 1'b0;
            fifo_din  <= 8'h00;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (state == START) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift[bit_idx] <= rxs;
            end
            fifo_wr <= wr_set;
            if (wr_set) begin
                fifo_din <= shift;
            end
            // A set event in the same cycle as clr_err wins
            if (fe_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (pe_set) begin
            parity_err <= 1'b1;
        end else if (clr_err) begin
            parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// Self-checking bench for uart_rx_fifo_feeder: directed plus random frames against a frame-level model.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_fifo_feeder;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // Write strobe is seen this many cycles after the negedge that drives the start bit low
    localparam int WR_LAT = 3 + CPB / 2 + (9 + PBITS) * CPB;

    typedef struct {
        int         t;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       fifo_full;
    logic       clr_err;
    logic       fifo_wr;
    logic [7:0] fifo_din;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    wr_t wr_log[$];
    wr_t exp_q[$];
    wr_t mon_e;
    int  pcyc = 0;
    int  log_idx = 0;
    int  rd_ptr = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    bit  exp_fe = 0;
    bit  exp_ovr = 0;
    bit  exp_pe = 0;

    uart_rx_fifo_feeder #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .fifo_full  (fifo_full),
        .clr_err    (clr_err),
        .fifo_wr    (fifo_wr),
        .fifo_din   (fifo_din),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    // Every high cycle of fifo_wr is logged, so a stretched pulse shows up as an extra write
    always @(negedge clk) begin
        if (fifo_wr) begin
            mon_e.t = pcyc;
            mon_e.d = fifo_din;
            wr_log.push_back(mon_e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic apply_stimulus(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                              input int stop_len);
        int  t0;
        bit  full;
        bit  par_ok;
        wr_t e;
        full      = (wr_log.size() - rd_ptr) >= 16;
        fifo_full = full;
        t0        = pcyc;
`ifdef UART_RX_PARITY_EN
        par_ok = ((^b) == par_bit);
`else
        par_ok = 1'b1;
`endif
        apply_stimulus(1'b0, CPB);
        for (int i = 0; i < 8; i++) apply_stimulus(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        apply_stimulus(par_bit, CPB);
`endif
        apply_stimulus(stop_bit, stop_len);
        if (!par_ok) begin
            exp_pe = 1;
        end else if (!stop_bit) begin
            exp_fe = 1;
        end else if (full) begin
            exp_ovr = 1;
        end else begin
            e.t = t0 + WR_LAT;
            e.d = b;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_output(input string tag, input logic exp_busy);
        wr_t e;
        chk($sformatf("%s_wr_count", tag), wr_log.size() - log_idx, exp_q.size());
        while (log_idx < wr_log.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_wr_time", tag), wr_log[log_idx].t, e.t);
            chk($sformatf("%s_wr_data", tag), {24'd0, wr_log[log_idx].d}, {24'd0, e.d});
            log_idx++;
        end
        log_idx = wr_log.size();
        exp_q.delete();
        chk($sformatf("%s_busy", tag), {31'd0, busy}, {31'd0, exp_busy});
        chk($sformatf("%s_frame_err", tag), {31'd0, frame_err}, {31'd0, exp_fe});
        chk($sformatf("%s_overrun", tag), {31'd0, overrun}, {31'd0, exp_ovr});
        chk($sformatf("%s_parity_err", tag), {31'd0, parity_err}, {31'd0, exp_pe});
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        exp_fe  = 0;
        exp_ovr = 0;
        exp_pe  = 0;
    endtask

    initial begin
        logic [7:0] b;
        rst       = 1'b1;
        rx        = 1'b1;
        fifo_full = 1'b0;
        clr_err   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
        chk("rst_fifo_din", {24'd0, fifo_din}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
        rst = 1'b0;
        apply_stimulus(1'b1, 5);

        $display("[TB] single byte 0xA5");
        send_frame(8'hA5, 1'b1, ^8'hA5, CPB);
        apply_stimulus(1'b1, 20);
        check_output("a5", 1'b0);
        chk("din_hold", {24'd0, fifo_din}, 32'hA5);
        rd_ptr = wr_log.size();

        $display("[TB] back-to-back 0x00 0xFF");
        send_frame(8'h00, 1'b1, 1'b0, CPB);
        send_frame(8'hFF, 1'b1, 1'b0, CPB);
        apply_stimulus(1'b1, 20);
        check_output("b2b", 1'b0);
        rd_ptr = wr_log.size();

        $display("[TB] random fill to full, then overrun");
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            apply_stimulus(1'b1, $urandom_range(0, 3));
            send_frame(b, 1'b1, ^b, CPB);
        end
        apply_stimulus(1'b1, 20);
        check_output("fill", 1'b0);
        send_frame(8'h3C, 1'b1, ^8'h3C, CPB);
        apply_stimulus(1'b1, 20);
        check_output("overrun", 1'b0);
        pulse_clr();
        check_output("clr_ovr", 1'b0);
        rd_ptr = wr_log.size();

        $display("[TB] framing error with held-low stop");
        send_frame(8'h81, 1'b0, ^8'h81, 40);
        chk("fe_busy_low", {31'd0, busy}, 32'd1);
        apply_stimulus(1'b1, 10);
        check_output("frame_err", 1'b0);
        pulse_clr();
        check_output("clr_fe", 1'b0);

        $display("[TB] start-bit glitch");
        apply_stimulus(1'b0, 4);
        apply_stimulus(1'b1, 30);
        check_output("glitch", 1'b0);

        $display("[TB] reset during data of 0x55");
        apply_stimulus(1'b0, CPB);
        apply_stimulus(1'b1, CPB);
        apply_stimulus(1'b0, CPB / 2);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
        chk("mid_rst_fifo_din", {24'd0, fifo_din}, 32'd0);
        rst = 1'b0;
        apply_stimulus(1'b1, 200);
        check_output("rst_mid", 1'b0);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity good and bad");
        send_frame(8'h07, 1'b1, 1'b1, CPB);
        apply_stimulus(1'b1, 20);
        check_output("par_good", 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, CPB);
        apply_stimulus(1'b1, 20);
        check_output("par_bad", 1'b0);
        pulse_clr();
        check_output("clr_pe", 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
